// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported memory between instruction fetch and load/store; data wins ties.
// Latency : request in IDLE at cycle 0 -> mem_req at cycle 1; mem_ack at cycle k -> done/rdata at k+1 -> IDLE at k+2.
// Backpressure: requesters hold req until their done pulse; the memory stalls the arbiter by withholding mem_ack.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_done              fetch requester
//   d_req/d_we/d_be/d_addr/d_wdata -> d_rdata/d_done load/store requester
//   err                          accompanies a done pulse when that access timed out
//   busy                         any state other than IDLE (decoded from the state register)
//   mem_req/we/be/addr/wdata, mem_rdata/mem_ack      memory macro port
//
// Optional build macro MEM_TIMEOUT_EN: abandon an access after TIMEOUT_CYCLES wait cycles
// without mem_ack and complete it with err=1 and zero read data. Without it the arbiter
// waits indefinitely and err is tied low.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Data first: the load/store belongs to the instruction already in flight.
                    if (d_req) begin
                        state     <= D_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else if (if_req) begin
                        state     <= I_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'hF;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end

                I_WAIT: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        if_rdata <= '0;
                        if_done  <= 1'b1;
                        err_q    <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                D_WAIT: begin
                    if (mem_ack) begin
                        // A store completes without touching d_rdata.
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                        d_done  <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        if (!mem_we)
                            d_rdata <= '0;
                        d_done   <= 1'b1;
                        err_q    <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    // The done pulse was raised on entry; drop it so it lasts exactly one cycle.
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
